// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam int         WORD_BYTES = 4;

  function automatic logic addr_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: one synchronous write port, one asynchronous read port.
module dmem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder with valid/ready request and response handshakes.
// Optional one-entry posted write buffer enabled by defining DMEM_WRITE_BUFFER_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [32:0] LIMIT    = 33'(WORD_BYTES * DEPTH);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, req_err, cmt, fast_store;

  logic          we_p0, err_p0;
  logic [AW-1:0] idx_p0;
  logic          err_p1;
  logic [31:0]   rdata_p1;

  logic          cur_we, cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   ld_data;

  logic          arr_we;
  logic [AW-1:0] arr_waddr;
  logic [31:0]   arr_wdata, arr_rdata;

  assign req_err = addr_misaligned(req_addr[1:0]) | ({1'b0, req_addr} >= LIMIT);
  assign accept  = req_valid & req_ready;

  // In IDLE the commit may happen on the accepting edge, so use the live request.
  assign cur_we  = (state == IDLE) ? req_we  : we_p0;
  assign cur_err = (state == IDLE) ? req_err : err_p0;
  assign cur_idx = (state == IDLE) ? req_addr[AW+1:2] : idx_p0;

  always_comb begin
    state_nxt = state;
    cmt       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err || fast_store || LATENCY == 1) begin
            state_nxt = RESP;
            cmt       = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          cmt       = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DMEM_WRITE_BUFFER_EN
  logic          wb_vld, wb_load, drain;
  logic [AW-1:0] wb_idx;
  logic [31:0]   wb_data;

  // A store finding the buffer occupied is held off for one drain cycle.
  assign req_ready  = (state == IDLE) & ~(wb_vld & req_valid & req_we);
  assign fast_store = req_we & ~req_err;
  assign wb_load    = accept & req_we & ~req_err;
  assign drain      = (state == IDLE) & ~accept & wb_vld;
  assign ld_data    = (wb_vld && wb_idx == cur_idx) ? wb_data : arr_rdata;

  assign arr_we    = drain & ~reset;
  assign arr_waddr = wb_idx;
  assign arr_wdata = wb_data;

  always_ff @(posedge clk) begin
    if (reset)        wb_vld <= 1'b0;
    else if (wb_load) wb_vld <= 1'b1;
    else if (drain)   wb_vld <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wb_load) begin
      wb_idx  <= req_addr[AW+1:2];
      wb_data <= req_wdata;
    end
  end
`else
  logic [31:0] wdata_p0, cur_wdata;

  assign req_ready  = (state == IDLE);
  assign fast_store = 1'b0;
  assign ld_data    = arr_rdata;
  assign cur_wdata  = (state == IDLE) ? req_wdata : wdata_p0;

  // Gating with reset discards a store whose commit edge coincides with reset.
  assign arr_we    = cmt & cur_we & ~cur_err & ~reset;
  assign arr_waddr = cur_idx;
  assign arr_wdata = cur_wdata;

  always_ff @(posedge clk) begin
    if (accept) wdata_p0 <= req_wdata;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (accept)                           cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // Stage p0: request latch at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0  <= req_we;
      err_p0 <= req_err;
      idx_p0 <= req_addr[AW+1:2];
    end
  end

  // Stage p1: response captured at commit, held until consumed
  always_ff @(posedge clk) begin
    if (cmt) begin
      err_p1   <= cur_err;
      rdata_p1 <= (cur_err | cur_we) ? 32'd0 : ld_data;
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_rdata = resp_valid ? rdata_p1 : 32'd0;
  assign resp_err   = resp_valid & err_p1;
  assign busy       = (state != IDLE);

  dmem_array #(.DEPTH(DEPTH), .DATA_W(32), .AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (cur_idx),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-vector bench for dmem_responder (DEPTH=1024, LATENCY=2).
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_WRITE_BUFFER_EN
  localparam int ST_LAT = 1;
`else
  localparam int ST_LAT = LAT;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  int vectors    = 0;
  int miscompares = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One full request/response exchange; lat = edges from accept until resp_valid seen.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL txn_ready_timeout addr=%h: req_ready never rose", addr);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat >= 40) begin
      miscompares++;
      $display("FAIL txn_resp_timeout addr=%h: resp_valid never rose", addr);
    end
    rd = resp_rdata;
    er = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    vectors += 5;
    if (req_ready !== 1'b1)   begin miscompares++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    if (resp_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL rst_resp_rdata got=%h want=0", resp_rdata); end
    if (resp_err !== 1'b0)    begin miscompares++; $display("FAIL rst_resp_err got=%b want=0", resp_err); end
    if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy got=%b want=0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    vectors += 3;
    if (lat !== ST_LAT)  begin miscompares++; $display("FAIL sw10_latency got=%0d want=%0d", lat, ST_LAT); end
    if (er !== 1'b0)     begin miscompares++; $display("FAIL sw10_err got=%b want=0", er); end
    if (rd !== 32'd0)    begin miscompares++; $display("FAIL sw10_rdata got=%h want=0", rd); end
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    vectors += 3;
    if (lat !== LAT)          begin miscompares++; $display("FAIL lw10_latency got=%0d want=%0d", lat, LAT); end
    if (er !== 1'b0)          begin miscompares++; $display("FAIL lw10_err got=%b want=0", er); end
    if (rd !== 32'hDEADBEEF)  begin miscompares++; $display("FAIL lw10_rdata got=%h want=deadbeef", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 32'h12, 32'h0, rd, er, lat);
    vectors += 3;
    if (er !== 1'b1)  begin miscompares++; $display("FAIL lw12_err got=%b want=1", er); end
    if (rd !== 32'd0) begin miscompares++; $display("FAIL lw12_rdata got=%h want=0", rd); end
    if (lat !== 1)    begin miscompares++; $display("FAIL lw12_latency got=%0d want=1", lat); end
    txn(1'b0, 32'h1000, 32'h0, rd, er, lat);
    vectors += 3;
    if (er !== 1'b1)  begin miscompares++; $display("FAIL lw1000_err got=%b want=1", er); end
    if (rd !== 32'd0) begin miscompares++; $display("FAIL lw1000_rdata got=%h want=0", rd); end
    if (lat !== 1)    begin miscompares++; $display("FAIL lw1000_latency got=%0d want=1", lat); end
    // An out-of-range store must not alias onto word 0, nor a misaligned one onto its word.
    txn(1'b1, 32'h0, 32'h11111111, rd, er, lat);
    txn(1'b1, 32'h1000, 32'h0BAD0BAD, rd, er, lat);
    vectors++;
    if (er !== 1'b1) begin miscompares++; $display("FAIL sw1000_err got=%b want=1", er); end
    txn(1'b1, 32'h12, 32'h0BAD0BAD, rd, er, lat);
    txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'h11111111) begin miscompares++; $display("FAIL lw0_after_err got=%h want=11111111", rd); end
    txn(1'b0, 32'h10, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw10_after_err got=%h want=deadbeef", rd); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n;
    txn(1'b1, 32'hC, 32'h3, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'hC; resp_ready = 1'b0;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n >= 20) begin miscompares++; $display("FAIL bp_resp_timeout: resp_valid never rose"); end
    for (int i = 0; i < 5; i++) begin
      vectors += 4;
      if (resp_rdata !== 32'h3) begin miscompares++; $display("FAIL bp_rdata cyc=%0d got=%h want=3", i, resp_rdata); end
      if (resp_valid !== 1'b1)  begin miscompares++; $display("FAIL bp_resp_valid cyc=%0d got=%b want=1", i, resp_valid); end
      if (req_ready !== 1'b0)   begin miscompares++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0", i, req_ready); end
      if (busy !== 1'b1)        begin miscompares++; $display("FAIL bp_busy cyc=%0d got=%b want=1", i, busy); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    vectors += 2;
    if (busy !== 1'b0)      begin miscompares++; $display("FAIL bp_release_busy got=%b want=0", busy); end
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd; logic er; int lat; int n;
    txn(1'b1, 32'h20, 32'h0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; resp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy got=%b want=1", busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors += 4;
    if (busy !== 1'b0)        begin miscompares++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    if (resp_valid !== 1'b0)  begin miscompares++; $display("FAIL mid_rst_resp_valid got=%b want=0", resp_valid); end
    if (req_ready !== 1'b1)   begin miscompares++; $display("FAIL mid_rst_req_ready got=%b want=1", req_ready); end
    if (resp_rdata !== 32'd0) begin miscompares++; $display("FAIL mid_rst_rdata got=%h want=0", resp_rdata); end
    txn(1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL lw20_after_rst got=%h want=0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; int n;
    logic exp_busy [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_rv   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_rdy  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    txn(1'b1, 32'h4, 32'h44, rd, er, lat);
    txn(1'b1, 32'h8, 32'h88, rd, er, lat);
    txn(1'b0, 32'h0, 32'h0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h4; resp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      vectors += 3;
      if (busy !== exp_busy[i])     begin miscompares++; $display("FAIL b2b_busy step=%0d got=%b want=%b", i, busy, exp_busy[i]); end
      if (resp_valid !== exp_rv[i]) begin miscompares++; $display("FAIL b2b_resp_valid step=%0d got=%b want=%b", i, resp_valid, exp_rv[i]); end
      if (req_ready !== exp_rdy[i]) begin miscompares++; $display("FAIL b2b_req_ready step=%0d got=%b want=%b", i, req_ready, exp_rdy[i]); end
      if (i == 1) begin
        vectors++;
        if (resp_rdata !== 32'h44) begin miscompares++; $display("FAIL b2b_rdata0 got=%h want=44", resp_rdata); end
        req_addr = 32'h8;
      end
      if (i == 4) begin
        vectors++;
        if (resp_rdata !== 32'h88) begin miscompares++; $display("FAIL b2b_rdata1 got=%h want=88", resp_rdata); end
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_write_buffer();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h40, 32'hA5, rd, er, lat);
    vectors += 2;
    if (lat !== ST_LAT) begin miscompares++; $display("FAIL sw40_latency got=%0d want=%0d", lat, ST_LAT); end
    if (er !== 1'b0)    begin miscompares++; $display("FAIL sw40_err got=%b want=0", er); end
    txn(1'b0, 32'h40, 32'h0, rd, er, lat);
    vectors += 2;
    if (rd !== 32'hA5) begin miscompares++; $display("FAIL lw40_fwd got=%h want=a5", rd); end
    if (lat !== LAT)   begin miscompares++; $display("FAIL lw40_latency got=%0d want=%0d", lat, LAT); end
    repeat (2) @(posedge clk);
    #1;
    txn(1'b0, 32'h40, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== 32'hA5) begin miscompares++; $display("FAIL lw40_drained got=%h want=a5", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid_store();
    test_back_to_back();
    test_write_buffer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
